smc_state_multi: RTL

- Parametrised next-generation static memory controller (SMC) timing engine. Drives the external memory strobes for NUM_CS chip selects.
- Holds its own leading-edge, wait-state, trailing-edge and beat counters; no external counter block is needed.
- Captures a per-chip-select timing set when an access is accepted. Supports multi-beat bursts and back-to-back accesses that keep the chip select asserted.
- Sits between the AHB interface (access requests) and the SMC pad/MAC logic (strobes, read latch).

---
 rtl/smc_state_multi.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/smc_state_multi.sv
// SMC timing engine: leading edge, wait states, trailing edge, bursts.
// Define SMC_EXT_WAIT_EN to add the n_ext_wait beat-extension input.
module smc_state_multi #(
  parameter int NUM_CS = 8,
  parameter int CS_W   = 3,
  parameter int WS_W   = 8,
  parameter int LE_W   = 2,
  parameter int TE_W   = 2,
  parameter int BEAT_W = 3
) (
  input  logic                   sys_clk1,
  input  logic                   sys_reset1,
  input  logic                   new_access,
  input  logic [CS_W-1:0]        acc_cs,
  input  logic                   acc_write,
  input  logic [BEAT_W-1:0]      acc_beats,
  input  logic [NUM_CS*LE_W-1:0] cfg_csle,
  input  logic [NUM_CS*WS_W-1:0] cfg_ws,
  input  logic [NUM_CS*TE_W-1:0] cfg_cste,
  input  logic [NUM_CS*2-1:0]    cfg_oete,
  output logic                   acc_ready,
  output logic [2:0]             smc_state,
  output logic                   smc_idle,
  output logic                   smc_done,
  output logic [NUM_CS-1:0]      cs_n,
  output logic                   oe_n,
  output logic                   we_n,
  output logic                   latch_data,
  output logic [BEAT_W-1:0]      beat_cnt
`ifdef SMC_EXT_WAIT_EN
  ,
  input  logic                   n_ext_wait
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_STORE = 3'd1,
    S_LE    = 3'd2,
    S_RW    = 3'd3,
    S_FLOAT = 3'd4
  } state_t;

  state_t state, state_nx;

  logic [LE_W-1:0]   le_cnt, le_nx;
  logic [WS_W-1:0]   ws_cnt, ws_nx;
  logic [TE_W-1:0]   te_cnt, te_nx;
  logic [BEAT_W-1:0] beat_nx;

  logic [CS_W-1:0] r_cs, cs_nx;
  logic            r_write, write_nx;
  logic [LE_W-1:0] r_csle, csle_nx;
  logic [WS_W-1:0] r_ws, rws_nx;
  logic [TE_W-1:0] r_cste, cste_nx;
  logic [1:0]      r_oete, oete_nx;

  logic [LE_W-1:0] sel_csle;
  logic [WS_W-1:0] sel_ws;
  logic [TE_W-1:0] sel_cste;
  logic [1:0]      sel_oete;

  logic ext_ok;
  logic accept;
  logic last_beat;
  logic eoa;
  logic same_tgt;
  logic active;

`ifdef SMC_EXT_WAIT_EN
  assign ext_ok = n_ext_wait;
`else
  assign ext_ok = 1'b1;
`endif

  // Pick the requested CS's timing; unknown index yields zero timing
  always_comb begin
    sel_csle = '0;
    sel_ws   = '0;
    sel_cste = '0;
    sel_oete = '0;
    for (int i = 0; i < NUM_CS; i++) begin
      if (acc_cs == CS_W'(i)) begin
        sel_csle = cfg_csle[i*LE_W +: LE_W];
        sel_ws   = cfg_ws[i*WS_W +: WS_W];
        sel_cste = cfg_cste[i*TE_W +: TE_W];
        sel_oete = cfg_oete[i*2 +: 2];
      end
    end
  end

  assign last_beat = (state == S_RW) && (ws_cnt == '0)
                  && ext_ok && (beat_cnt == '0);
  assign eoa = (last_beat && (r_cste == '0))
            || ((state == S_FLOAT) && (te_cnt == TE_W'(1)));
  assign acc_ready = !sys_reset1 && ((state == S_IDLE) || eoa);
  assign accept    = acc_ready && new_access;
  assign same_tgt  = (acc_cs == r_cs) && (acc_write == r_write);

  // Next state, counter reloads and snapshot capture
  always_comb begin
    state_nx = state;
    le_nx    = le_cnt;
    ws_nx    = ws_cnt;
    te_nx    = te_cnt;
    beat_nx  = beat_cnt;
    cs_nx    = r_cs;
    write_nx = r_write;
    csle_nx  = r_csle;
    rws_nx   = r_ws;
    cste_nx  = r_cste;
    oete_nx  = r_oete;
    unique case (state)
      S_IDLE: begin
        if (accept) state_nx = S_STORE;
      end
      S_STORE: begin
        le_nx = r_csle;
        if (r_csle != '0) begin
          state_nx = S_LE;
        end else begin
          state_nx = S_RW;
          ws_nx    = r_ws;
        end
      end
      S_LE: begin
        le_nx = le_cnt - 1'b1;
        if (le_cnt == LE_W'(1)) begin
          state_nx = S_RW;
          ws_nx    = r_ws;
        end
      end
      S_RW: begin
        if (ws_cnt != '0) begin
          ws_nx = ws_cnt - 1'b1;
        end else if (ext_ok) begin
          if (beat_cnt != '0) begin
            beat_nx = beat_cnt - 1'b1;
            if (r_csle != '0) begin
              state_nx = S_LE;
              le_nx    = r_csle;
            end else begin
              ws_nx = r_ws;
            end
          end else if (r_cste != '0) begin
            state_nx = S_FLOAT;
            te_nx    = r_cste;
          end else begin
            state_nx = S_IDLE;
          end
        end
      end
      S_FLOAT: begin
        te_nx = te_cnt - 1'b1;
        if (te_cnt == TE_W'(1)) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    if (eoa && new_access) begin
      if (same_tgt) begin
        if (sel_csle != '0) begin
          state_nx = S_LE;
          le_nx    = sel_csle;
        end else begin
          state_nx = S_RW;
          ws_nx    = sel_ws;
        end
      end else begin
        state_nx = S_STORE;
      end
    end
    if (accept) begin
      cs_nx    = acc_cs;
      write_nx = acc_write;
      beat_nx  = acc_beats;
      csle_nx  = sel_csle;
      rws_nx   = sel_ws;
      cste_nx  = sel_cste;
      oete_nx  = sel_oete;
    end
  end

  // State register
  always_ff @(posedge sys_clk1 or posedge sys_reset1) begin
    if (sys_reset1) state <= S_IDLE;
    else            state <= state_nx;
  end

  // Counters and captured access snapshot
  always_ff @(posedge sys_clk1 or posedge sys_reset1) begin
    if (sys_reset1) begin
      le_cnt   <= '0;
      ws_cnt   <= '0;
      te_cnt   <= '0;
      beat_cnt <= '0;
      r_cs     <= '0;
      r_write  <= 1'b0;
      r_csle   <= '0;
      r_ws     <= '0;
      r_cste   <= '0;
      r_oete   <= '0;
    end else begin
      le_cnt   <= le_nx;
      ws_cnt   <= ws_nx;
      te_cnt   <= te_nx;
      beat_cnt <= beat_nx;
      r_cs     <= cs_nx;
      r_write  <= write_nx;
      r_csle   <= csle_nx;
      r_ws     <= rws_nx;
      r_cste   <= cste_nx;
      r_oete   <= oete_nx;
    end
  end

  assign active = (state == S_LE) || (state == S_RW)
               || (state == S_FLOAT);

  // Chip-select decode from the captured index
  always_comb begin
    cs_n = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (active && (r_cs == CS_W'(i))) cs_n[i] = 1'b0;
    end
  end

  assign smc_state  = state;
  assign smc_idle   = (state_nx == S_IDLE);
  assign smc_done   = eoa;
  assign oe_n       = !((state == S_RW) && !r_write);
  assign we_n       = !((state == S_RW) && r_write
                     && (ws_cnt != '0));
  assign latch_data = (state == S_RW) && !r_write
                   && (ws_cnt <= {{(WS_W-2){1'b0}}, r_oete});

endmodule
